// File: rtl/sc_cmdsequencer.sv
// sc_cmdsequencer: scans active-low requests and issues one
// active-low command pulse per press, with optional auto-repeat.
module sc_cmdsequencer #(
  parameter int NUM_CH        = 2,
  parameter int PULSE_LEN     = 1,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DLY    = 16,
  parameter int REPEAT_PERIOD = 8,
  parameter int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int CNT_W         = 16
) (
  input  logic              SC_CMDSEQ_CLOCK_50,
  input  logic              SC_CMDSEQ_RESET_InLow,
  input  logic [NUM_CH-1:0] SC_CMDSEQ_req_InLow,
  output logic [NUM_CH-1:0] SC_CMDSEQ_cmd_OutLow,
  output logic              SC_CMDSEQ_busy_OutHigh,
  output logic [CH_W-1:0]   SC_CMDSEQ_chan_Out
);

  typedef enum logic [2:0] {
    RESET = 3'd0,
    START = 3'd1,
    CHECK = 3'd2,
    FIRE  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] PulseLast = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] DlyLast   = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] PerLast   = CNT_W'(REPEAT_PERIOD - 1);

  state_t           state, stateNx;
  logic [CNT_W-1:0] cnt, cntNx;
  logic             rptFlag, rptFlagNx;
  logic [CH_W-1:0]  chan, chanNx;

  logic             anyReq;
  logic [CH_W-1:0]  lowIdx;
  logic             reqHeld;
  logic [CNT_W-1:0] thr;

  // lowest-numbered active request wins
  always_comb begin
    lowIdx = '0;
    anyReq = ~&SC_CMDSEQ_req_InLow;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (!SC_CMDSEQ_req_InLow[i]) lowIdx = CH_W'(i);
    end
  end

  // whether the latched channel is still being requested
  always_comb begin
    reqHeld = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (chan == CH_W'(i)) reqHeld = !SC_CMDSEQ_req_InLow[i];
    end
  end

  // state, counter, repeat flag and channel registers
  always_ff @(posedge SC_CMDSEQ_CLOCK_50 or negedge SC_CMDSEQ_RESET_InLow) begin
    if (!SC_CMDSEQ_RESET_InLow) begin
      state   <= RESET;
      cnt     <= '0;
      rptFlag <= 1'b0;
      chan    <= '0;
    end else begin
      state   <= stateNx;
      cnt     <= cntNx;
      rptFlag <= rptFlagNx;
      chan    <= chanNx;
    end
  end

  // next-state logic; first repeat waits longer than later ones
  always_comb begin
    stateNx   = state;
    cntNx     = cnt;
    rptFlagNx = rptFlag;
    chanNx    = chan;
    thr       = rptFlag ? PerLast : DlyLast;
    case (state)
      RESET: stateNx = START;
      START: stateNx = CHECK;
      CHECK: begin
        if (anyReq) begin
          chanNx    = lowIdx;
          cntNx     = '0;
          rptFlagNx = 1'b0;
          stateNx   = FIRE;
        end
      end
      FIRE: begin
        if (cnt == PulseLast) begin
          cntNx   = '0;
          stateNx = HOLD;
        end else begin
          cntNx = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (!reqHeld) begin
          stateNx = CHECK;
        end else if (REPEAT_EN != 0) begin
          if (cnt == thr) begin
            rptFlagNx = 1'b1;
            cntNx     = '0;
            stateNx   = FIRE;
          end else begin
            cntNx = cnt + 1'b1;
          end
        end
      end
      default: stateNx = CHECK;
    endcase
  end

  // Moore outputs from state and latched channel only
  always_comb begin
    SC_CMDSEQ_cmd_OutLow = '1;
    if (state == FIRE) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (chan == CH_W'(i)) SC_CMDSEQ_cmd_OutLow[i] = 1'b0;
      end
    end
    SC_CMDSEQ_busy_OutHigh = (state == FIRE) || (state == HOLD);
    SC_CMDSEQ_chan_Out     = chan;
  end

endmodule

// File: tb/tb_sc_cmdsequencer.sv
// tb_sc_cmdsequencer: directed checks of the command sequencer
// across single, priority, repeat and long-pulse configurations.
module tb_sc_cmdsequencer;

  logic clk;
  logic rstN;

  logic [1:0] reqA, cmdA;
  logic       busyA;
  logic [0:0] chanA;

  logic [3:0] reqB, cmdB;
  logic       busyB;
  logic [1:0] chanB;

  logic [1:0] reqR, cmdR;
  logic       busyR;
  logic [0:0] chanR;

  logic [1:0] reqL, cmdL;
  logic       busyL;
  logic [0:0] chanL;

  int checks = 0;
  int errors = 0;

  sc_cmdsequencer #(.NUM_CH(2)) uA (
    .SC_CMDSEQ_CLOCK_50    (clk),
    .SC_CMDSEQ_RESET_InLow (rstN),
    .SC_CMDSEQ_req_InLow   (reqA),
    .SC_CMDSEQ_cmd_OutLow  (cmdA),
    .SC_CMDSEQ_busy_OutHigh(busyA),
    .SC_CMDSEQ_chan_Out    (chanA)
  );

  sc_cmdsequencer #(.NUM_CH(4)) uB (
    .SC_CMDSEQ_CLOCK_50    (clk),
    .SC_CMDSEQ_RESET_InLow (rstN),
    .SC_CMDSEQ_req_InLow   (reqB),
    .SC_CMDSEQ_cmd_OutLow  (cmdB),
    .SC_CMDSEQ_busy_OutHigh(busyB),
    .SC_CMDSEQ_chan_Out    (chanB)
  );

  sc_cmdsequencer #(
    .NUM_CH(2), .PULSE_LEN(1), .REPEAT_EN(1),
    .REPEAT_DLY(4), .REPEAT_PERIOD(2)
  ) uR (
    .SC_CMDSEQ_CLOCK_50    (clk),
    .SC_CMDSEQ_RESET_InLow (rstN),
    .SC_CMDSEQ_req_InLow   (reqR),
    .SC_CMDSEQ_cmd_OutLow  (cmdR),
    .SC_CMDSEQ_busy_OutHigh(busyR),
    .SC_CMDSEQ_chan_Out    (chanR)
  );

  sc_cmdsequencer #(.NUM_CH(2), .PULSE_LEN(5)) uL (
    .SC_CMDSEQ_CLOCK_50    (clk),
    .SC_CMDSEQ_RESET_InLow (rstN),
    .SC_CMDSEQ_req_InLow   (reqL),
    .SC_CMDSEQ_cmd_OutLow  (cmdL),
    .SC_CMDSEQ_busy_OutHigh(busyL),
    .SC_CMDSEQ_chan_Out    (chanL)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    repeat (3) tick();
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    reqA = '1; reqB = '1; reqR = '1; reqL = '1;
    rstN = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cmdA !== 2'b11 || busyA !== 1'b0 || chanA !== 1'b0) begin
        errors++;
        $display("FAIL rst_hold_A cmd=%b busy=%b chan=%0d want 11 0 0",
                 cmdA, busyA, chanA);
      end
      checks++;
      if (cmdB !== 4'hf || busyB !== 1'b0 || chanB !== 2'd0) begin
        errors++;
        $display("FAIL rst_hold_B cmd=%b busy=%b chan=%0d want 1111 0 0",
                 cmdB, busyB, chanB);
      end
      tick();
    end
    rstN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (cmdA !== 2'b11 || busyA !== 1'b0 || chanA !== 1'b0) begin
        errors++;
        $display("FAIL idle_A cyc=%0d cmd=%b busy=%b chan=%0d want 11 0 0",
                 i, cmdA, busyA, chanA);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    tick();
    tick();
    reqA = 2'b10;
    tick();
    checks++;
    if (cmdA !== 2'b10 || busyA !== 1'b1 || chanA !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse cmd=%b busy=%b chan=%0d want 10 1 0",
               cmdA, busyA, chanA);
    end
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (cmdA !== 2'b11 || busyA !== 1'b1) begin
        errors++;
        $display("FAIL single_hold cyc=%0d cmd=%b busy=%b want 11 1",
                 i, cmdA, busyA);
      end
    end
    reqA = 2'b11;
    tick();
    checks++;
    if (cmdA !== 2'b11 || busyA !== 1'b0) begin
      errors++;
      $display("FAIL single_release cmd=%b busy=%b want 11 0",
               cmdA, busyA);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (cmdA !== 2'b11 || busyA !== 1'b0) begin
        errors++;
        $display("FAIL single_after cyc=%0d cmd=%b busy=%b want 11 0",
                 i, cmdA, busyA);
      end
    end
  endtask

  task automatic test_priority();
    do_reset();
    reqB = 4'b0011;
    tick();
    tick();
    tick();
    checks++;
    if (cmdB !== 4'b1011 || chanB !== 2'd2 || busyB !== 1'b1) begin
      errors++;
      $display("FAIL prio_first cmd=%b chan=%0d busy=%b want 1011 2 1",
               cmdB, chanB, busyB);
    end
    tick();
    tick();
    checks++;
    if (cmdB !== 4'hf || chanB !== 2'd2 || busyB !== 1'b1) begin
      errors++;
      $display("FAIL prio_hold cmd=%b chan=%0d busy=%b want 1111 2 1",
               cmdB, chanB, busyB);
    end
    reqB = 4'b0111;
    tick();
    checks++;
    if (cmdB !== 4'hf || busyB !== 1'b0 || chanB !== 2'd2) begin
      errors++;
      $display("FAIL prio_check cmd=%b busy=%b chan=%0d want 1111 0 2",
               cmdB, busyB, chanB);
    end
    tick();
    checks++;
    if (cmdB !== 4'b0111 || chanB !== 2'd3 || busyB !== 1'b1) begin
      errors++;
      $display("FAIL prio_second cmd=%b chan=%0d busy=%b want 0111 3 1",
               cmdB, chanB, busyB);
    end
    tick();
    checks++;
    if (cmdB !== 4'hf || busyB !== 1'b1) begin
      errors++;
      $display("FAIL prio_hold2 cmd=%b busy=%b want 1111 1", cmdB, busyB);
    end
    reqB = 4'hf;
    tick();
  endtask

  task automatic test_repeat();
    logic [14:0] pat;
    pat = 15'b011011011011110;
    do_reset();
    reqR = 2'b10;
    tick();
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (cmdR[0] !== pat[i] || cmdR[1] !== 1'b1) begin
        errors++;
        $display("FAIL repeat_pat idx=%0d cmd=%b want %b1",
                 i, cmdR, pat[i]);
      end
    end
    reqR = 2'b11;
    tick();
    checks++;
    if (cmdR !== 2'b11 || busyR !== 1'b1) begin
      errors++;
      $display("FAIL repeat_rel_hold cmd=%b busy=%b want 11 1",
               cmdR, busyR);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (cmdR !== 2'b11 || busyR !== 1'b0) begin
        errors++;
        $display("FAIL repeat_stop cyc=%0d cmd=%b busy=%b want 11 0",
                 i, cmdR, busyR);
      end
    end
  endtask

  task automatic test_long_pulse();
    do_reset();
    reqL = 2'b01;
    tick();
    tick();
    tick();
    reqL = 2'b11;
    checks++;
    if (cmdL !== 2'b01 || chanL !== 1'b1 || busyL !== 1'b1) begin
      errors++;
      $display("FAIL long_start cmd=%b chan=%0d busy=%b want 01 1 1",
               cmdL, chanL, busyL);
    end
    for (int i = 1; i < 5; i++) begin
      tick();
      checks++;
      if (cmdL !== 2'b01 || busyL !== 1'b1) begin
        errors++;
        $display("FAIL long_body cyc=%0d cmd=%b busy=%b want 01 1",
                 i, cmdL, busyL);
      end
    end
    tick();
    checks++;
    if (cmdL !== 2'b11 || busyL !== 1'b1) begin
      errors++;
      $display("FAIL long_hold cmd=%b busy=%b want 11 1", cmdL, busyL);
    end
    tick();
    checks++;
    if (cmdL !== 2'b11 || busyL !== 1'b0) begin
      errors++;
      $display("FAIL long_check cmd=%b busy=%b want 11 0", cmdL, busyL);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    reqL = 2'b01;
    tick();
    tick();
    tick();
    tick();
    tick();
    checks++;
    if (cmdL !== 2'b01) begin
      errors++;
      $display("FAIL mid_pulse3 cmd=%b want 01", cmdL);
    end
    #2;
    rstN = 1'b0;
    #1;
    checks++;
    if (cmdL !== 2'b11 || busyL !== 1'b0 || chanL !== 1'b0) begin
      errors++;
      $display("FAIL mid_async cmd=%b busy=%b chan=%0d want 11 0 0",
               cmdL, busyL, chanL);
    end
    tick();
    tick();
    rstN = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (cmdL !== 2'b11 || busyL !== 1'b0) begin
        errors++;
        $display("FAIL mid_idle edge=%0d cmd=%b busy=%b want 11 0",
                 i + 1, cmdL, busyL);
      end
    end
    tick();
    checks++;
    if (cmdL !== 2'b01 || busyL !== 1'b1) begin
      errors++;
      $display("FAIL mid_restart cmd=%b busy=%b want 01 1", cmdL, busyL);
    end
    reqL = 2'b11;
    repeat (8) tick();
  endtask

  initial begin
    rstN = 1'b0;
    reqA = '1; reqB = '1; reqR = '1; reqL = '1;
    test_reset();
    test_single();
    test_priority();
    test_repeat();
    test_long_pulse();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
